// File: rtl/store_align_unit.sv
// Store-path aligner: lane-shifts store data into byte-enabled bus beats and
// splits stores that straddle a bus word into two sequential write beats.
module store_align_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_data,
    input  logic [1:0]          req_size,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_byte_enable,
    input  logic                mem_resp,
    output logic                done,
    output logic                err
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OB = $clog2(NB);
    localparam int unsigned MW = 2 * NB;
    localparam int unsigned DW = 2 * XLEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
    logic [XLEN-1:0]    mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]      mem_be_q, mem_be_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  b1_addr_q, b1_addr_d;
    logic [XLEN-1:0]    b1_data_q, b1_data_d;
    logic [NB-1:0]      b1_be_q, b1_be_d;
    logic               need_b1_q, need_b1_d;

    logic [OB-1:0]      ofs_c;
    logic [7:0]         size_mask_c;
    logic [XLEN-1:0]    data_trim_c;
    logic [MW-1:0]      mask_c;
    logic [DW-1:0]      data_c;
    logic [ADDR_W-1:0]  base_addr_c;
    logic               illegal_c;

    // Alignment math on the raw request; only consumed on the accept edge.
    always_comb begin
        ofs_c = req_addr[OB-1:0];
        case (req_size)
            2'b00:   size_mask_c = 8'h01;
            2'b01:   size_mask_c = 8'h03;
            2'b10:   size_mask_c = 8'h0F;
            default: size_mask_c = 8'hFF;
        endcase
        for (int i = 0; i < NB; i++) begin
            data_trim_c[8*i +: 8] = size_mask_c[i] ? req_data[8*i +: 8] : 8'h00;
        end
        mask_c      = MW'(size_mask_c) << ofs_c;
        data_c      = DW'(data_trim_c) << {ofs_c, 3'b000};
        base_addr_c = {req_addr[ADDR_W-1:OB], {OB{1'b0}}};
        illegal_c   = (req_size == 2'b11) && (XLEN == 32);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        b1_addr_d     = b1_addr_q;
        b1_data_d     = b1_data_q;
        b1_be_d       = b1_be_q;
        need_b1_d     = need_b1_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (illegal_c) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d       = BEAT0;
                        mem_write_d   = 1'b1;
                        mem_address_d = base_addr_c;
                        mem_wdata_d   = data_c[XLEN-1:0];
                        mem_be_d      = mask_c[NB-1:0];
                        b1_addr_d     = base_addr_c + ADDR_W'(NB);
                        b1_data_d     = data_c[DW-1:XLEN];
                        b1_be_d       = mask_c[MW-1:NB];
                        need_b1_d     = |mask_c[MW-1:NB];
                    end
                end
            end
            BEAT0: begin
                if (mem_resp) begin
                    if (need_b1_q) begin
                        state_d       = BEAT1;
                        mem_address_d = b1_addr_q;
                        mem_wdata_d   = b1_data_q;
                        mem_be_d      = b1_be_q;
                    end else begin
                        state_d       = IDLE;
                        mem_write_d   = 1'b0;
                        mem_address_d = '0;
                        mem_wdata_d   = '0;
                        mem_be_d      = '0;
                        done_d        = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_resp) begin
                    state_d       = IDLE;
                    mem_write_d   = 1'b0;
                    mem_address_d = '0;
                    mem_wdata_d   = '0;
                    mem_be_d      = '0;
                    done_d        = 1'b1;
                end
            end
            default: begin
                state_d       = IDLE;
                mem_write_d   = 1'b0;
                mem_address_d = '0;
                mem_wdata_d   = '0;
                mem_be_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            b1_addr_q     <= '0;
            b1_data_q     <= '0;
            b1_be_q       <= '0;
            need_b1_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            done_q        <= done_d;
            err_q         <= err_d;
            b1_addr_q     <= b1_addr_d;
            b1_data_q     <= b1_data_d;
            b1_be_q       <= b1_be_d;
            need_b1_q     <= need_b1_d;
        end
    end

    // Ready is a pure state decode so the MEM stage sees the stall without an input path.
    assign req_ready       = (state_q == IDLE);
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_be_q;
    assign done            = done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: vector table through a beat scoreboard at XLEN=32,
// plus hand-written reset-abort and XLEN=64 sequences.
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, mem_write, mem_resp, done, err;
    logic [31:0] req_addr, req_data, mem_address, mem_wdata;
    logic [1:0]  req_size;
    logic [3:0]  mem_byte_enable;

    logic        req_valid_w, req_ready_w, mem_write_w, mem_resp_w, done_w, err_w;
    logic [31:0] req_addr_w, mem_address_w;
    logic [63:0] req_data_w, mem_wdata_w;
    logic [1:0]  req_size_w;
    logic [7:0]  mem_byte_enable_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    store_align_unit #(.XLEN(32), .ADDR_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp),
        .done(done), .err(err)
    );

    store_align_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_w), .req_ready(req_ready_w),
        .req_addr(req_addr_w), .req_data(req_data_w), .req_size(req_size_w),
        .mem_write(mem_write_w), .mem_address(mem_address_w), .mem_wdata(mem_wdata_w),
        .mem_byte_enable(mem_byte_enable_w), .mem_resp(mem_resp_w),
        .done(done_w), .err(err_w)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        bit          last;
        bit          is_err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        int          waits;
        bit          intrude;
        int          nbeats;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [3:0]  b0;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [3:0]  b1;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_vec(input vec_t v);
        exp_t e;
        if (v.nbeats == 0) begin
            e = '{addr: 32'h0, data: 32'h0, be: 4'h0, last: 1'b1, is_err: 1'b1};
            sb.push_back(e);
        end else begin
            e = '{addr: v.a0, data: v.d0, be: v.b0, last: (v.nbeats == 1), is_err: 1'b0};
            sb.push_back(e);
            if (v.nbeats == 2) begin
                e = '{addr: v.a1, data: v.d1, be: v.b1, last: 1'b1, is_err: 1'b0};
                sb.push_back(e);
            end
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (sb.size() != 0);
        e  = '{addr: 32'h0, data: 32'h0, be: 4'h0, last: 1'b1, is_err: 1'b0};
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic chk_beat(input string tag, input exp_t e);
        chk({tag, "_mem_write"}, 64'(mem_write), 64'(1));
        chk({tag, "_addr"}, 64'(mem_address), 64'(e.addr));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(e.data));
        chk({tag, "_be"}, 64'(mem_byte_enable), 64'(e.be));
        chk({tag, "_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
    endtask

    // Drive one request at a negedge, serve its beats, and return one idle negedge later.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        bit   ok;
        string tag;
        tag = $sformatf("v%0d", idx);
        chk({tag, "_ready_idle"}, 64'(req_ready), 64'(1));
        push_vec(v);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_data  = v.data;
        req_size  = v.size;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        @(negedge clk);
        if (v.nbeats == 0) begin
            pop_exp(e, ok);
            chk({tag, "_err_done"}, 64'(done), 64'(1));
            chk({tag, "_err_err"}, 64'(err), 64'(e.is_err));
            chk({tag, "_err_nowrite"}, 64'(mem_write), 64'(0));
        end else begin
            for (int b = 0; b < v.nbeats; b++) begin
                pop_exp(e, ok);
                if (!ok) break;
                chk_beat($sformatf("%s_b%0d", tag, b), e);
                for (int w = 0; w < v.waits; w++) begin
                    if (v.intrude) begin
                        req_valid = 1'b1;
                        req_addr  = $urandom;
                        req_data  = $urandom;
                        req_size  = 2'b00;
                    end
                    @(negedge clk);
                    chk_beat($sformatf("%s_b%0d_hold%0d", tag, b, w), e);
                end
                req_valid = 1'b0;
                mem_resp  = 1'b1;
                @(negedge clk);
                mem_resp  = 1'b0;
                if (e.last) begin
                    chk({tag, "_done"}, 64'(done), 64'(1));
                    chk({tag, "_err0"}, 64'(err), 64'(0));
                    chk({tag, "_ready_done"}, 64'(req_ready), 64'(1));
                    chk({tag, "_mw_done"}, 64'(mem_write), 64'(0));
                end
            end
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'(0));
        chk({tag, "_err_pulse"}, 64'(err), 64'(0));
        chk({tag, "_no_phantom"}, 64'(mem_write), 64'(0));
    endtask

    initial begin
        exp_t e;
        bit   ok;

        vecs[0] = '{32'h0000_1003, 32'hFFFF_FFAB, 2'b00, 0, 1'b0, 1,
                    32'h0000_1000, 32'hAB00_0000, 4'b1000, 32'h0, 32'h0, 4'h0};
        vecs[1] = '{32'h0000_1002, 32'h0000_1234, 2'b01, 0, 1'b0, 1,
                    32'h0000_1000, 32'h1234_0000, 4'b1100, 32'h0, 32'h0, 4'h0};
        vecs[2] = '{32'h0000_1001, 32'hDDCC_BBAA, 2'b10, 0, 1'b0, 2,
                    32'h0000_1000, 32'hCCBB_AA00, 4'b1110, 32'h0000_1004, 32'h0000_00DD, 4'b0001};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01, 0, 1'b0, 2,
                    32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000, 32'h0000_0000, 32'h0000_00BE, 4'b0001};
        vecs[4] = '{32'h0000_1001, 32'hDDCC_BBAA, 2'b10, 5, 1'b1, 2,
                    32'h0000_1000, 32'hCCBB_AA00, 4'b1110, 32'h0000_1004, 32'h0000_00DD, 4'b0001};
        vecs[5] = '{32'h0000_1000, 32'h1234_5678, 2'b11, 0, 1'b0, 0,
                    32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
        vecs[6] = '{32'h0000_1000, 32'h1234_5678, 2'b00, 0, 1'b0, 1,
                    32'h0000_1000, 32'h0000_0078, 4'b0001, 32'h0, 32'h0, 4'h0};
        vecs[7] = '{32'h0000_1003, 32'h0000_1234, 2'b01, 1, 1'b0, 2,
                    32'h0000_1000, 32'h3400_0000, 4'b1000, 32'h0000_1004, 32'h0000_0012, 4'b0001};
        vecs[8] = '{32'h0000_2000, 32'h89AB_CDEF, 2'b10, 2, 1'b0, 1,
                    32'h0000_2000, 32'h89AB_CDEF, 4'b1111, 32'h0, 32'h0, 4'h0};

        req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_resp = 1'b0;
        req_valid_w = 1'b0; req_addr_w = '0; req_data_w = '0; req_size_w = '0; mem_resp_w = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_write", 64'(mem_write), 64'(0));
        chk("rst_addr", 64'(mem_address), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_be", 64'(mem_byte_enable), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'(1));

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end
        chk("sb_drained", 64'(sb.size()), 64'(0));

        // Reset while the second beat of a split store is outstanding.
        push_vec(vecs[2]);
        req_valid = 1'b1; req_addr = 32'h0000_1001; req_data = 32'hDDCC_BBAA; req_size = 2'b10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        pop_exp(e, ok);
        chk_beat("rstab_b0", e);
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        pop_exp(e, ok);
        chk_beat("rstab_b1", e);
        #2 rst_n = 1'b0;
        #1;
        chk("rstab_mem_write", 64'(mem_write), 64'(0));
        chk("rstab_be", 64'(mem_byte_enable), 64'(0));
        chk("rstab_wdata", 64'(mem_wdata), 64'(0));
        chk("rstab_addr", 64'(mem_address), 64'(0));
        chk("rstab_done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstab_ready", 64'(req_ready), 64'(1));
        chk("rstab_idle", 64'(mem_write), 64'(0));
        run_vec(9, vecs[1]);

        // XLEN=64 instance: split dword, then an unaligned word kept in one beat.
        @(negedge clk);
        req_valid_w = 1'b1; req_addr_w = 32'h0000_2004;
        req_data_w = 64'h1122_3344_5566_7788; req_size_w = 2'b11;
        @(posedge clk);
        #1 req_valid_w = 1'b0;
        @(negedge clk);
        chk("x64_sd_b0_mw", 64'(mem_write_w), 64'(1));
        chk("x64_sd_b0_addr", 64'(mem_address_w), 64'h2000);
        chk("x64_sd_b0_wdata", mem_wdata_w, 64'h5566_7788_0000_0000);
        chk("x64_sd_b0_be", 64'(mem_byte_enable_w), 64'hF0);
        mem_resp_w = 1'b1;
        @(negedge clk);
        mem_resp_w = 1'b0;
        chk("x64_sd_b1_mw", 64'(mem_write_w), 64'(1));
        chk("x64_sd_b1_addr", 64'(mem_address_w), 64'h2008);
        chk("x64_sd_b1_wdata", mem_wdata_w, 64'h0000_0000_1122_3344);
        chk("x64_sd_b1_be", 64'(mem_byte_enable_w), 64'h0F);
        mem_resp_w = 1'b1;
        @(negedge clk);
        mem_resp_w = 1'b0;
        chk("x64_sd_done", 64'(done_w), 64'(1));
        chk("x64_sd_err", 64'(err_w), 64'(0));

        req_valid_w = 1'b1; req_addr_w = 32'h0000_3002;
        req_data_w = 64'hFFFF_FFFF_AABB_CCDD; req_size_w = 2'b10;
        @(posedge clk);
        #1 req_valid_w = 1'b0;
        @(negedge clk);
        chk("x64_sw_addr", 64'(mem_address_w), 64'h3000);
        chk("x64_sw_wdata", mem_wdata_w, 64'h0000_AABB_CCDD_0000);
        chk("x64_sw_be", 64'(mem_byte_enable_w), 64'h3C);
        mem_resp_w = 1'b1;
        @(negedge clk);
        mem_resp_w = 1'b0;
        chk("x64_sw_done", 64'(done_w), 64'(1));
        chk("x64_sw_mw", 64'(mem_write_w), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
